vlc_row_binarizer: RTL and testbench

//  Front-end stage of the VLC receiver, directly behind the camera byte stream (start/datain).
//  - Packs raster-order R,G,B bytes into pixels and thresholds each pixel's luma.
//  - Reduces each image row (one rolling-shutter stripe line) to one bright/dark bit.
//  - Feeds the downstream stripe/bit decoder with one row_valid strobe per row.

---
 rtl/vlc_rx_pkg.sv | 21 ++
 rtl/rgb_pixel_packer.sv | 31 +++
 rtl/vlc_row_binarizer.sv | 156 +++++++++++++++
 tb/tb_vlc_row_binarizer.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlc_rx_pkg.sv
// Shared definitions for the VLC receiver front end: FSM states, default
// geometry/threshold and the R+2G+B luma helper.
package vlc_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam int DEF_WIDHT    = 180;
    localparam int DEF_HEIGTH   = 350;
    localparam int DEF_TRESHOLD = 90;

    // 8+9+8 bit terms fit comfortably in 10 bits (max 1020).
    function automatic logic [9:0] luma_sum(input logic [7:0] r, input logic [7:0] g,
                                            input logic [7:0] b);
        return {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};
    endfunction

endpackage

// File: rtl/rgb_pixel_packer.sv
// Holds the R and G bytes of the current pixel and presents the luma sum
// combinationally while the B byte is on the input.
module rgb_pixel_packer
    import vlc_rx_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       byte_en,
    input  logic [1:0] phase,
    input  logic [7:0] datain,
    output logic       pix_valid,
    output logic [9:0] luma
);

    logic [7:0] r_reg;
    logic [7:0] g_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_reg <= '0;
            g_reg <= '0;
        end else if (byte_en) begin
            if (phase == 2'd0) r_reg <= datain;
            if (phase == 2'd1) g_reg <= datain;
        end
    end

    assign pix_valid = byte_en && (phase == 2'd2);
    assign luma      = luma_sum(r_reg, g_reg, datain);

endmodule

// File: rtl/vlc_row_binarizer.sv
// Camera byte stream to one bright/dark bit per image row.
// Optional ROW_CNT_OUT_EN exposes the per-row bright-pixel count on row_cnt.
module vlc_row_binarizer
    import vlc_rx_pkg::*;
#(
    parameter int WIDHT    = DEF_WIDHT,
    parameter int HEIGTH   = DEF_HEIGTH,
    parameter int TRESHOLD = DEF_TRESHOLD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [7:0]                datain,
    output logic                      row_valid,
    output logic                      row_bit,
    output logic [$clog2(HEIGTH)-1:0] row_idx,
    output logic                      frame_done,
    output logic                      frame_abort
`ifdef ROW_CNT_OUT_EN
    ,
    output logic [$clog2(WIDHT+1)-1:0] row_cnt
`endif
);

    localparam int COL_W = $clog2(WIDHT);
    localparam int ROW_W = $clog2(HEIGTH);
    localparam int CNT_W = $clog2(WIDHT + 1);

    localparam logic [9:0]       LUMA_THR = 10'(4 * TRESHOLD);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDHT - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGTH - 1);
    localparam logic [CNT_W:0]   WIDHT_X  = (CNT_W + 1)'(WIDHT);

    state_t            state_reg, state_next;
    logic [1:0]        phase_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ROW_W-1:0]  row_reg;
    logic [CNT_W-1:0]  bright_cnt_reg;
    logic [CNT_W-1:0]  cnt_final;
    logic [CNT_W:0]    cnt_x2;

    logic              byte_en;
    logic              pix_valid;
    logic [9:0]        luma;
    logic              bright;
    logic              row_end;
    logic              frame_end;
    logic              row_bit_next;

    logic              row_valid_reg;
    logic              row_bit_reg;
    logic [ROW_W-1:0]  row_idx_reg;
    logic              frame_done_reg;
    logic              frame_abort_reg;
`ifdef ROW_CNT_OUT_EN
    logic [CNT_W-1:0]  row_cnt_reg;
`endif

    // Overrun bytes in DONE must not touch the datapath.
    assign byte_en = start && (state_reg != ST_DONE);

    rgb_pixel_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .byte_en   (byte_en),
        .phase     (phase_reg),
        .datain    (datain),
        .pix_valid (pix_valid),
        .luma      (luma)
    );

    always_comb begin
        bright       = (luma >= LUMA_THR);
        cnt_final    = bright_cnt_reg + {{(CNT_W-1){1'b0}}, bright};
        cnt_x2       = {cnt_final, 1'b0};
        row_bit_next = (cnt_x2 > WIDHT_X);
        row_end      = pix_valid && (col_reg == COL_LAST);
        frame_end    = row_end && (row_reg == ROW_LAST);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (start) state_next = ST_STREAM;
            ST_STREAM: begin
                if (!start)         state_next = ST_IDLE;
                else if (frame_end) state_next = ST_DONE;
            end
            ST_DONE:   if (!start) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_reg <= ST_IDLE;
        else     state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_reg       <= '0;
            col_reg         <= '0;
            row_reg         <= '0;
            bright_cnt_reg  <= '0;
            row_valid_reg   <= 1'b0;
            row_bit_reg     <= 1'b0;
            row_idx_reg     <= '0;
            frame_done_reg  <= 1'b0;
            frame_abort_reg <= 1'b0;
`ifdef ROW_CNT_OUT_EN
            row_cnt_reg     <= '0;
`endif
        end else begin
            row_valid_reg   <= 1'b0;
            frame_done_reg  <= 1'b0;
            frame_abort_reg <= 1'b0;
            if (state_reg == ST_STREAM && !start) begin
                // Partial frame: drop the partial row and rewind for the next frame.
                frame_abort_reg <= 1'b1;
                phase_reg       <= '0;
                col_reg         <= '0;
                row_reg         <= '0;
                bright_cnt_reg  <= '0;
            end else if (byte_en) begin
                phase_reg <= (phase_reg == 2'd2) ? 2'd0 : phase_reg + 2'd1;
                if (pix_valid) begin
                    if (row_end) begin
                        row_valid_reg  <= 1'b1;
                        row_bit_reg    <= row_bit_next;
                        row_idx_reg    <= row_reg;
                        frame_done_reg <= frame_end;
`ifdef ROW_CNT_OUT_EN
                        row_cnt_reg    <= cnt_final;
`endif
                        bright_cnt_reg <= '0;
                        col_reg        <= '0;
                        row_reg        <= frame_end ? '0 : row_reg + ROW_W'(1);
                    end else begin
                        bright_cnt_reg <= cnt_final;
                        col_reg        <= col_reg + COL_W'(1);
                    end
                end
            end
        end
    end

    assign row_valid   = row_valid_reg;
    assign row_bit     = row_bit_reg;
    assign row_idx     = row_idx_reg;
    assign frame_done  = frame_done_reg;
    assign frame_abort = frame_abort_reg;
`ifdef ROW_CNT_OUT_EN
    assign row_cnt     = row_cnt_reg;
`endif

endmodule

// File: tb/tb_vlc_row_binarizer.sv
// Directed bench for vlc_row_binarizer: full row width, short frame height so
// every scenario runs quickly; a row-level model predicts every row report.
module tb_vlc_row_binarizer;

    localparam int W  = 180;
    localparam int H  = 8;
    localparam int T  = 90;
    localparam int RB = 3 * W;
    localparam int FB = 3 * W * H;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    start;
    logic [7:0]              datain;
    logic                    row_valid;
    logic                    row_bit;
    logic [$clog2(H)-1:0]    row_idx;
    logic                    frame_done;
    logic                    frame_abort;
`ifdef ROW_CNT_OUT_EN
    logic [$clog2(W+1)-1:0]  row_cnt;
`endif

    vlc_row_binarizer #(.WIDHT(W), .HEIGTH(H), .TRESHOLD(T)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .datain      (datain),
        .row_valid   (row_valid),
        .row_bit     (row_bit),
        .row_idx     (row_idx),
        .frame_done  (frame_done),
        .frame_abort (frame_abort)
`ifdef ROW_CNT_OUT_EN
        ,
        .row_cnt     (row_cnt)
`endif
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int idx;
        int b;
        int cnt;
        int fd;
    } ev_t;

    ev_t expq[$];
    ev_t cur_e;
    bit  chk_en = 1'b0;
    int  hold_bit = 0, hold_idx = 0, hold_cnt = 0;
    int  rv_count = 0, fd_count = 0, abort_count = 0;
    int  dut_bit_arr[H];
    int  dut_cnt_arr[H];
    bit  lat_arm = 1'b0;
    int  first_rv_cyc = 0;
    int  last_start_cyc = 0;

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Stimulus image content, addressed by mode/row/col/channel (0=R,1=G,2=B).
    function automatic logic [7:0] pix_byte(input int mode, input int row, input int col,
                                            input int ch);
        logic [7:0] v;
        case (mode)
            0: v = 8'hFF;
            1: v = (row % 2 == 0) ? 8'hFF : 8'h00;
            2: case (row % 5)
                   0: v = 8'd90;
                   1: v = 8'd89;
                   2: v = (col < 90) ? 8'hFF : 8'h00;
                   3: v = (col < 91) ? 8'hFF : 8'h00;
                   default: v = (ch == 1) ? 8'd60 : 8'd120;
               endcase
            default: v = 8'((row * 37 + col * 11 + ch * 53) % 256);
        endcase
        return v;
    endfunction

    function automatic int row_count(input int mode, input int row);
        int n = 0;
        for (int c = 0; c < W; c++) begin
            if (int'(pix_byte(mode, row, c, 0)) + 2 * int'(pix_byte(mode, row, c, 1))
                + int'(pix_byte(mode, row, c, 2)) >= 4 * T)
                n++;
        end
        return n;
    endfunction

    task automatic expect_rows(input int mode, input int nrows);
        ev_t e;
        for (int r = 0; r < nrows; r++) begin
            e.idx = r;
            e.cnt = row_count(mode, r);
            e.b   = (2 * e.cnt > W) ? 1 : 0;
            e.fd  = (r == H - 1) ? 1 : 0;
            expq.push_back(e);
        end
    endtask

    task automatic drive_bytes(input int mode, input int nbytes, input bit drop_after);
        for (int i = 0; i < nbytes; i++) begin
            @(posedge clk); #1;
            start = 1'b1;
            if (i == 0) last_start_cyc = cyc;
            if (i >= FB) datain = 8'hFF;
            else         datain = pix_byte(mode, i / RB, (i / 3) % W, i % 3);
        end
        if (drop_after) begin
            @(posedge clk); #1;
            start  = 1'b0;
            datain = 8'h00;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            start  = 1'b0;
            datain = 8'h00;
        end
    endtask

    // Row reports are popped from the model queue; outside a report the
    // outputs must hold the last reported row.
    always @(negedge clk) begin
        if (chk_en) begin
            if (row_valid) begin
                if (lat_arm) begin
                    first_rv_cyc = cyc;
                    lat_arm = 1'b0;
                end
                rv_count++;
                if (frame_done) fd_count++;
                dut_bit_arr[int'(row_idx)] = int'(row_bit);
`ifdef ROW_CNT_OUT_EN
                dut_cnt_arr[int'(row_idx)] = int'(row_cnt);
`endif
                if (expq.size() == 0) begin
                    check("unexpected_row_valid_idx", int'(row_idx), -1);
                end else begin
                    cur_e = expq.pop_front();
                    check("row_idx", int'(row_idx), cur_e.idx);
                    check("row_bit", int'(row_bit), cur_e.b);
                    check("frame_done", int'(frame_done), cur_e.fd);
`ifdef ROW_CNT_OUT_EN
                    check("row_cnt", int'(row_cnt), cur_e.cnt);
`endif
                    hold_bit = cur_e.b;
                    hold_idx = cur_e.idx;
                    hold_cnt = cur_e.cnt;
                end
            end else begin
                check("frame_done_without_row", int'(frame_done), 0);
                check("hold_row_bit", int'(row_bit), hold_bit);
                check("hold_row_idx", int'(row_idx), hold_idx);
`ifdef ROW_CNT_OUT_EN
                check("hold_row_cnt", int'(row_cnt), hold_cnt);
`endif
            end
            if (frame_abort) abort_count++;
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog_timeout got=%0d want=0", cyc);
        $fatal(1, "timeout");
    end

    int rv0, fd0, ab0;

    initial begin
        for (int i = 0; i < H; i++) begin
            dut_bit_arr[i] = -1;
            dut_cnt_arr[i] = -1;
        end
        rst = 1'b1; start = 1'b0; datain = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        check("reset_row_valid", int'(row_valid), 0);
        check("reset_row_bit", int'(row_bit), 0);
        check("reset_row_idx", int'(row_idx), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_frame_abort", int'(frame_abort), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk_en = 1'b1;
        idle(2);

        // Model pins: hand-computed row counts.
        check("model_cnt_all90", row_count(2, 0), 180);
        check("model_cnt_all89", row_count(2, 1), 0);
        check("model_cnt_tie90", row_count(2, 2), 90);

        // 1: all-white frame.
        rv0 = rv_count; fd0 = fd_count;
        expect_rows(0, H);
        drive_bytes(0, FB, 1'b1);
        idle(4);
        check("t1_queue_left", expq.size(), 0);
        check("t1_row_valid_count", rv_count - rv0, H);
        check("t1_frame_done_count", fd_count - fd0, 1);
        for (int r = 0; r < H; r++) check("t1_row_bit", dut_bit_arr[r], 1);
`ifdef ROW_CNT_OUT_EN
        check("t1_row_cnt_last", dut_cnt_arr[H-1], 180);
`endif

        // 2: stripes, plus first-report latency (541st cycle counting the start-rise cycle).
        expect_rows(1, H);
        lat_arm = 1'b1;
        drive_bytes(1, FB, 1'b1);
        idle(4);
        check("t2_queue_left", expq.size(), 0);
        check("t2_first_latency", first_rv_cyc - last_start_cyc, 540);
        check("t2_row0_bit", dut_bit_arr[0], 1);
        check("t2_row1_bit", dut_bit_arr[1], 0);
        check("t2_row6_bit", dut_bit_arr[6], 1);
        check("t2_row7_bit", dut_bit_arr[7], 0);

        // 3: threshold and majority boundaries.
        expect_rows(2, H);
        drive_bytes(2, FB, 1'b1);
        idle(4);
        check("t3_queue_left", expq.size(), 0);
        check("t3_luma_eq_thr", dut_bit_arr[0], 1);
        check("t3_luma_below_thr", dut_bit_arr[1], 0);
        check("t3_tie_90", dut_bit_arr[2], 0);
        check("t3_majority_91", dut_bit_arr[3], 1);
        check("t3_green_weight", dut_bit_arr[4], 1);
`ifdef ROW_CNT_OUT_EN
        check("t3_cnt_all90", dut_cnt_arr[0], 180);
        check("t3_cnt_all89", dut_cnt_arr[1], 0);
        check("t3_cnt_tie", dut_cnt_arr[2], 90);
        check("t3_cnt_91", dut_cnt_arr[3], 91);
`endif

        // 4: 1000-byte overrun with start still high.
        rv0 = rv_count; fd0 = fd_count;
        expect_rows(0, H);
        drive_bytes(0, FB + 1000, 1'b1);
        idle(4);
        check("t4_queue_left", expq.size(), 0);
        check("t4_row_valid_count", rv_count - rv0, H);
        check("t4_frame_done_count", fd_count - fd0, 1);

        // 5: start drops after 1000 bytes, then a clean frame.
        rv0 = rv_count; fd0 = fd_count; ab0 = abort_count;
        expect_rows(0, 1);
        drive_bytes(0, 1000, 1'b1);
        idle(4);
        check("t5_queue_left", expq.size(), 0);
        check("t5_abort_count", abort_count - ab0, 1);
        check("t5_frame_done_count", fd_count - fd0, 0);
        check("t5_row_valid_count", rv_count - rv0, 1);
        expect_rows(3, H);
        drive_bytes(3, FB, 1'b1);
        idle(4);
        check("t5_next_queue_left", expq.size(), 0);

        // 6: reset mid-row 5, then a fresh all-white frame.
        ab0 = abort_count;
        expect_rows(0, 5);
        drive_bytes(0, 5 * RB + 200, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1; start = 1'b0; datain = 8'h00;
        chk_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        hold_bit = 0; hold_idx = 0; hold_cnt = 0;
        #1;
        check("t6_rst_row_valid", int'(row_valid), 0);
        check("t6_rst_row_bit", int'(row_bit), 0);
        check("t6_rst_row_idx", int'(row_idx), 0);
        check("t6_rst_frame_done", int'(frame_done), 0);
        check("t6_rst_frame_abort", int'(frame_abort), 0);
        chk_en = 1'b1;
        check("t6_queue_before_rst", expq.size(), 0);
        idle(2);
        rv0 = rv_count; fd0 = fd_count;
        expect_rows(0, H);
        drive_bytes(0, FB, 1'b1);
        idle(4);
        check("t6_queue_left", expq.size(), 0);
        check("t6_row_valid_count", rv_count - rv0, H);
        check("t6_frame_done_count", fd_count - fd0, 1);
        check("t6_no_abort", abort_count - ab0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
